input_debouncer: RTL and testbench

- Front-end conditioning stage for an asynchronous single-bit input such as a pin, switch or external strobe.
- Synchronises the raw input into the clock domain and rejects bounces and glitches shorter than a programmable window.
- Outputs a clean level plus one-cycle rise and fall pulses.
- clean_out feeds the downstream registered single-bit consumers (the myin-style inputs) in the same clock domain.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/sync_chain.sv | 25 ++
 rtl/input_debouncer.sv | 118 +++++++++++
 tb/tb_input_debouncer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the input debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } deb_state_t;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Committed level is high while stable high or while qualifying a drop.
  function automatic logic level_of(input deb_state_t s);
    return (s == STABLE_HIGH) || (s == CHECK_LOW);
  endfunction

  function automatic logic is_check(input deb_state_t s);
    return (s == CHECK_HIGH) || (s == CHECK_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - N-flop synchroniser with reset value, async active-low reset
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise and debounce a raw input, emit clean level and edge pulses
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = 8,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("input_debouncer: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce_cycles
    $error("input_debouncer: DEBOUNCE_CYCLES must be 2..(2^CNT_W)-1");
  end

  localparam deb_state_t       RESET_STATE = RESET_VAL ? STABLE_HIGH : STABLE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             sync_in;
  deb_state_t       state;
  deb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             rise_next;
  logic             fall_next;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync_chain (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (sync_in)
  );

  // Outputs are derived from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      clean_out  <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      clean_out  <= level_of(state_next);
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      busy       <= is_check(state_next);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync_in && enable) begin
          state_next = CHECK_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        // Disable wins over a pending commit so nothing qualifies while disabled.
        if (!enable || !sync_in) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync_in && enable) begin
          state_next = CHECK_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (!enable || sync_in) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

  logic clock;
  logic reset_n;
  logic enable;
  logic raw_in;
  logic clean_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  logic reset_b;
  logic enable_b;
  logic raw_b;
  logic clean_b;
  logic rise_b;
  logic fall_b;
  logic busy_b;

  int checks;
  int errors;

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .CNT_W           (8),
    .RESET_VAL       (1'b0)
  ) dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  input_debouncer #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (2),
    .CNT_W           (8),
    .RESET_VAL       (1'b0)
  ) dut_b (
    .clock      (clock),
    .reset_n    (reset_b),
    .enable     (enable_b),
    .raw_in     (raw_b),
    .clean_out  (clean_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .busy       (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Outputs packed as {clean, rise, fall, busy}.
  task automatic test_reset();
    logic [3:0] got;
    logic [3:0] exp;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got %b expected 0000", i, got);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      exp = {k >= 18, k == 18, 1'b0, (k >= 3 && k <= 17)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_rise edge %0d got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_fall();
    logic [3:0] got;
    logic [3:0] exp;
    for (int k = 1; k <= 20; k++) begin
      raw_in = 1'b0;
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      exp = {k < 18, 1'b0, k == 18, (k >= 3 && k <= 17)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_fall edge %0d got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got;
    logic [3:0] exp;
    for (int k = 1; k <= 20; k++) begin
      raw_in = (k <= 10);
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      exp = {1'b0, 1'b0, 1'b0, (k >= 3 && k <= 12)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce edge %0d got %b expected %b", k, got, exp);
      end
    end
    checks++;
    if (dut_a.cnt !== 8'd0) begin
      errors++;
      $display("FAIL bounce_cnt got %0d expected 0", dut_a.cnt);
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] got;
    logic [3:0] exp;
    for (int k = 1; k <= 40; k++) begin
      raw_in = 1'b1;
      enable = !(k >= 11 && k <= 20);
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      exp = {k >= 36, k == 36, 1'b0, ((k >= 3 && k <= 10) || (k >= 21 && k <= 35))};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable_drop edge %0d got %b expected %b", k, got, exp);
      end
      if (k == 10 || k == 21) begin
        checks++;
        if (dut_a.cnt !== ((k == 10) ? 8'd8 : 8'd1)) begin
          errors++;
          $display("FAIL enable_drop_cnt edge %0d got %0d expected %0d", k, dut_a.cnt, (k == 10) ? 8 : 1);
        end
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [3:0] got;
    logic [3:0] exp;
    raw_in = 1'b0;
    repeat (20) tick();
    checks++;
    if (clean_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pre got %b expected 0", clean_out);
    end
    for (int k = 1; k <= 14; k++) begin
      raw_in = 1'b1;
      tick();
    end
    checks++;
    if (dut_a.cnt !== 8'd12 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_cnt got cnt %0d busy %b expected cnt 12 busy 1", dut_a.cnt, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {clean_out, rise_pulse, fall_pulse, busy};
    checks++;
    if (got !== 4'b0000 || dut_a.cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_async got %b cnt %0d expected 0000 cnt 0", got, dut_a.cnt);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      got = {clean_out, rise_pulse, fall_pulse, busy};
      exp = {k >= 18, k == 18, 1'b0, (k >= 3 && k <= 17)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset_restart edge %0d got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_boundary();
    int raw_t[14]   = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int clean_t[14] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    int rise_t[14]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int fall_t[14]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int busy_t[14]  = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    logic [3:0] got;
    logic [3:0] exp;
    raw_b    = 1'b0;
    enable_b = 1'b1;
    tick();
    reset_b = 1'b1;
    for (int k = 0; k < 14; k++) begin
      raw_b = raw_t[k][0];
      tick();
      got = {clean_b, rise_b, fall_b, busy_b};
      exp = {clean_t[k][0], rise_t[k][0], fall_t[k][0], busy_t[k][0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL boundary_toggle edge %0d got %b expected %b", k + 1, got, exp);
      end
    end
    for (int j = 1; j <= 8; j++) begin
      raw_b = (j == 1);
      tick();
      got = {clean_b, rise_b, fall_b, busy_b};
      exp = {3'b000, j == 4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL boundary_glitch edge %0d got %b expected %b", j, got, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    raw_in   = 1'b1;
    reset_b  = 1'b0;
    enable_b = 1'b1;
    raw_b    = 1'b0;
    test_reset();
    test_clean_fall();
    test_bounce();
    test_enable_drop();
    test_mid_reset();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
